quantser_multi: RTL and testbench
=================================

QUANTSER_MULTI -- requirements
Module: quantser_multi

Interface
REQ-001 SHALL have parameter NCH, default 8, number of parallel channels.
REQ-002 SHALL have parameter BDIN, default 32, input word bit depth per channel.
REQ-003 SHALL have parameter BDOUTMAX, default 32, max output precision; BDOUTMAX <= BDIN.
REQ-004 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port clr_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-006 SHALL have port msbidx  input  $clog2(BDIN)  bit position of field MSB in din; sampled on accepted start.
REQ-007 SHALL have port bdout  input  $clog2(BDOUTMAX)  output bit depth minus one; sampled on accepted start.
REQ-008 SHALL have port start  input  1  request to capture din and begin serializing.
REQ-009 SHALL have port din  input  NCH*BDIN  channel c occupies bits [c*BDIN +: BDIN], unsigned.
REQ-010 SHALL have port busy  output  1  high while a word is being shifted out.
REQ-011 SHALL have port dout  output  NCH  serialized bit per channel, MSB first.
REQ-012 SHALL have port dout_valid  output  1  dout carries a valid bit this cycle.
REQ-013 SHALL have port dout_last  output  1  current dout bit is the LSB of the word.
REQ-014 SHALL have port start_drop  output  1  one-cycle pulse when a start is ignored.

Function
REQ-015 SHALL implement FSM states IDLE and SHIFT; IDLE->SHIFT on accepted start; SHIFT->IDLE after the LSB cycle unless a start is accepted that cycle.
REQ-016 SHALL accept start when state is IDLE, or in SHIFT during the dout_last cycle (back-to-back).
REQ-017 SHALL ignore start in SHIFT when dout_last=0, not alter the word in flight, and assert start_drop the next cycle.
REQ-018 SHALL, on accepted start, capture per channel field F = bits [msbidx : msbidx-bdout] of the channel word, width bd = bdout+1.
REQ-019 SHALL, when msbidx < bdout, fill field bit positions below din bit 0 with zero (F = din[msbidx:0] left-shifted by bdout-msbidx).
REQ-020 SHALL present the MSB of F on dout in the cycle after the accepting edge (latency 1), then one bit per cycle, bd cycles total.
REQ-021 SHALL hold dout_valid=1 for exactly bd consecutive cycles per word; dout_last=1 only on the final one.
REQ-022 SHALL, on back-to-back start, output the next word's MSB in the cycle immediately after the previous LSB, with no gap and dout_valid staying high.
REQ-023 SHALL drive dout=0 whenever dout_valid=0.
REQ-024 SHALL drive busy = (state==SHIFT).
REQ-025 SHALL use one shared bit counter for all channels, counting bdout down to 0.

Reset
REQ-026 SHALL, while clr_n=0 at a rising edge, set state IDLE, counter 0, shift registers 0, and busy, dout, dout_valid, dout_last, start_drop all 0.
REQ-027 SHALL abort any word in flight on reset with no further valid bits; start asserted during reset is ignored without start_drop.

Configuration
REQ-028 SHALL support macro QUANTSER_MULTI_SAT_EN; when defined, a channel with any din bit above msbidx set SHALL serialize F = all ones (bd bits) instead of the truncated field.
REQ-029 SHALL, without QUANTSER_MULTI_SAT_EN, discard bits above msbidx (plain truncation) and contain no saturation logic.

Verification
REQ-030 SHALL cover: NCH=8, bdout=0, msbidx=3, ch0 din=0x8 -> one valid cycle, dout[0]=1, dout_last=1, other channels 0.
REQ-031 SHALL cover: bdout=1, msbidx=31, ch0 din=0x80000000, ch1 din=0xC0000000 -> ch0 bits 1,0; ch1 bits 1,1; 2 valid cycles.
REQ-032 SHALL cover: bdout=31, msbidx=31, ch0 din=5 -> 32-bit stream equals 0x00000005, dout_last on 32nd valid cycle.
REQ-033 SHALL cover: bdout=3, msbidx=7, back-to-back start on dout_last with din 0xA0 then 0x50 -> bits 1010 then 0101 over 8 contiguous valid cycles; start mid-word -> start_drop pulse, stream unchanged.
REQ-034 SHALL cover: bdout=3, msbidx=3, din=0x13 -> with QUANTSER_MULTI_SAT_EN 1111, without 0011.
REQ-035 SHALL cover: clr_n=0 during 3rd bit of a 8-bit word -> next cycle all outputs 0, busy 0; next start serializes normally.

Source files
------------

// File: rtl/quantser_multi.sv
// rtl/quantser_multi.sv - multi-channel field extractor and MSB-first bit serializer
//
// Ports:
//   clk         rising-edge clock
//   clr_n       synchronous active-low reset
//   msbidx      bit position of the field MSB within each channel word (sampled on accepted start)
//   bdout       output bit depth minus one (sampled on accepted start)
//   start       request to capture din and begin serializing
//   din         NCH packed unsigned channel words, channel c at [c*BDIN +: BDIN]
//   busy        high while a word is being shifted out
//   dout        one serialized bit per channel, MSB first, zero when not valid
//   dout_valid  dout carries a valid bit this cycle
//   dout_last   current dout bit is the LSB of the word
//   start_drop  one-cycle pulse after a start that was ignored
//
// Optional feature: define QUANTSER_MULTI_SAT_EN to saturate a channel's field to all
// ones when any din bit above msbidx is set (default build truncates).
module quantser_multi #(
  parameter int NCH      = 8,
  parameter int BDIN     = 32,
  parameter int BDOUTMAX = 32
) (
  input  logic                        clk,
  input  logic                        clr_n,
  input  logic [$clog2(BDIN)-1:0]     msbidx,
  input  logic [$clog2(BDOUTMAX)-1:0] bdout,
  input  logic                        start,
  input  logic [NCH*BDIN-1:0]         din,
  output logic                        busy,
  output logic [NCH-1:0]              dout,
  output logic                        dout_valid,
  output logic                        dout_last,
  output logic                        start_drop
);

  localparam int MW = $clog2(BDIN);
  localparam int BW = $clog2(BDOUTMAX);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [BW-1:0]       cnt;
  logic [BDOUTMAX-1:0] sr        [NCH];
  logic [BDOUTMAX-1:0] load_word [NCH];
  logic                accept;
  logic [BW:0]         bd;
  logic [BDOUTMAX-1:0] mask;
  logic [MW-1:0]       align_sh;

  // Field is kept MSB-aligned in the shift register so the output is always the top bit.
  // mask keeps exactly the top bd bits; the bits below are zero.
  assign bd       = {1'b0, bdout} + (BW+1)'(1);
  assign mask     = ~({BDOUTMAX{1'b1}} >> bd);
  assign align_sh = MW'(BDIN - 1) - msbidx;

  assign busy       = (state == SHIFT);
  assign dout_valid = (state == SHIFT);
  assign dout_last  = (state == SHIFT) && (cnt == '0);
  assign accept     = start && ((state == IDLE) || dout_last);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [BDIN-1:0]     word;
    logic [BDIN-1:0]     aligned;
    logic [BDOUTMAX-1:0] field;

    assign word = din[c*BDIN +: BDIN];
    // Left shift puts din[msbidx] at the top; when msbidx < bdout the bits
    // shifted in from below are zero, giving the required zero fill.
    assign aligned = word << align_sh;
    assign field   = aligned[BDIN-1 -: BDOUTMAX] & mask;

`ifdef QUANTSER_MULTI_SAT_EN
    logic over;
    assign over         = |((word >> msbidx) >> 1);
    assign load_word[c] = over ? mask : field;
`else
    assign load_word[c] = field;
`endif

    assign dout[c] = (state == SHIFT) ? sr[c][BDOUTMAX-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (dout_last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt        <= '0;
      start_drop <= 1'b0;
      for (int c = 0; c < NCH; c++) sr[c] <= '0;
    end else begin
      start_drop <= start && (state == SHIFT) && !dout_last;
      if (accept) begin
        cnt <= bdout;
        for (int c = 0; c < NCH; c++) sr[c] <= load_word[c];
      end else if (state == SHIFT) begin
        if (cnt != '0) cnt <= cnt - BW'(1);
        for (int c = 0; c < NCH; c++) sr[c] <= sr[c] << 1;
      end
    end
  end

endmodule

// File: tb/tb_quantser_multi.sv
// tb/tb_quantser_multi.sv - directed self-checking bench for quantser_multi
module tb_quantser_multi;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [4:0]   msbidx;
  logic [4:0]   bdout;
  logic         start;
  logic [255:0] din;
  logic         busy;
  logic [7:0]   dout;
  logic         dout_valid;
  logic         dout_last;
  logic         start_drop;

  int checks = 0;
  int errors = 0;

  logic [31:0] s0;
  int          nvalid;
  int          lastpos;
  int          nlast;
  logic [7:0]  s8;

  quantser_multi #(.NCH(8), .BDIN(32), .BDOUTMAX(32)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .msbidx     (msbidx),
    .bdout      (bdout),
    .start      (start),
    .din        (din),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .start_drop (start_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Collects ch0 bits while dout_valid is high, bounded to 40 cycles.
  task automatic collect(output logic [31:0] s, output int nv, output int lp, output int nl);
    s  = '0;
    nv = 0;
    lp = -1;
    nl = 0;
    for (int i = 0; i < 40; i++) begin
      if (!dout_valid) break;
      s = {s[30:0], dout[0]};
      if (dout_last) begin
        lp = i;
        nl++;
      end
      nv++;
      tick();
    end
  endtask

  initial begin
    clr_n  = 1'b0;
    start  = 1'b0;
    msbidx = '0;
    bdout  = '0;
    din    = '0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_busy",  busy,       1'b0);
    check("rst_dout",  dout,       8'h00);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_last",  dout_last,  1'b0);
    check("rst_drop",  start_drop, 1'b0);
    clr_n = 1'b1;
    tick();
    check("idle_drop", start_drop, 1'b0);

    // single-bit word
    msbidx = 5'd3; bdout = 5'd0; din = '0; din[31:0] = 32'h8;
    do_start();
    check("b0_valid", dout_valid, 1'b1);
    check("b0_dout",  dout,       8'h01);
    check("b0_last",  dout_last,  1'b1);
    check("b0_busy",  busy,       1'b1);
    tick();
    check("b0_end_valid", dout_valid, 1'b0);
    check("b0_end_busy",  busy,       1'b0);
    check("b0_end_dout",  dout,       8'h00);

    // two channels, two bits
    msbidx = 5'd31; bdout = 5'd1; din = '0;
    din[31:0] = 32'h8000_0000; din[63:32] = 32'hC000_0000;
    do_start();
    check("b1_c0_dout", dout,      8'h03);
    check("b1_c0_last", dout_last, 1'b0);
    tick();
    check("b1_c1_dout", dout,      8'h02);
    check("b1_c1_last", dout_last, 1'b1);
    tick();
    check("b1_end_valid", dout_valid, 1'b0);

    // full 32-bit word
    msbidx = 5'd31; bdout = 5'd31; din = '0; din[31:0] = 32'h5;
    do_start();
    collect(s0, nvalid, lastpos, nlast);
    check("w32_stream",  s0,      32'h0000_0005);
    check("w32_nvalid",  nvalid,  32);
    check("w32_lastpos", lastpos, 31);
    check("w32_nlast",   nlast,   1);

    // zero fill below bit 0: msbidx=2, bdout=4, din=101 -> 10100
    msbidx = 5'd2; bdout = 5'd4; din = '0; din[31:0] = 32'h5;
    do_start();
    collect(s0, nvalid, lastpos, nlast);
    check("zf_stream", s0,     32'h14);
    check("zf_nvalid", nvalid, 5);

    // back-to-back and mid-word start
    msbidx = 5'd7; bdout = 5'd3; din = '0; din[31:0] = 32'hA0;
    do_start();
    s8 = '0;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      s8 = {s8[6:0], dout[0]};
      if (dout_valid) nvalid++;
      if (i == 2) check("b2b_drop_pulse", start_drop, 1'b1);
      if (i == 3) begin
        check("b2b_last3", dout_last, 1'b1);
        check("b2b_drop_once", start_drop, 1'b0);
      end
      if (i == 4) check("b2b_nodrop_accept", start_drop, 1'b0);
      if (i == 7) check("b2b_last7", dout_last, 1'b1);
      start = 1'b0;
      if (i == 1) begin
        start = 1'b1;
        din[31:0] = 32'hFF;
      end
      if (i == 3) begin
        start = 1'b1;
        din[31:0] = 32'h50;
      end
      tick();
    end
    start = 1'b0;
    check("b2b_stream", s8,     8'hA5);
    check("b2b_nvalid", nvalid, 8);
    check("b2b_end_valid", dout_valid, 1'b0);
    check("b2b_end_busy",  busy,       1'b0);

    // bits above msbidx: truncate or saturate
    msbidx = 5'd3; bdout = 5'd3; din = '0; din[31:0] = 32'h13;
    do_start();
    collect(s0, nvalid, lastpos, nlast);
`ifdef QUANTSER_MULTI_SAT_EN
    check("sat_stream", s0, 32'hF);
`else
    check("sat_stream", s0, 32'h3);
`endif
    check("sat_nvalid", nvalid, 4);

    // reset during 3rd bit of an 8-bit word
    msbidx = 5'd7; bdout = 5'd7; din = '0; din[31:0] = 32'hFF;
    do_start();
    tick();
    tick();
    check("rst3_valid_before", dout_valid, 1'b1);
    clr_n = 1'b0;
    start = 1'b1;
    tick();
    check("rst3_busy",  busy,       1'b0);
    check("rst3_dout",  dout,       8'h00);
    check("rst3_valid", dout_valid, 1'b0);
    check("rst3_last",  dout_last,  1'b0);
    check("rst3_drop",  start_drop, 1'b0);
    clr_n = 1'b1;
    start = 1'b0;
    tick();
    check("rst3_idle_valid", dout_valid, 1'b0);
    check("rst3_idle_drop",  start_drop, 1'b0);
    din[31:0] = 32'h3C;
    do_start();
    collect(s0, nvalid, lastpos, nlast);
    check("rst3_next_stream",  s0,      32'h3C);
    check("rst3_next_nvalid",  nvalid,  8);
    check("rst3_next_lastpos", lastpos, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
